// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// datapath mux/ALU selects, trap causes and the branch condition decoder.
package uc_pkg;

  typedef enum logic [6:0] {
    RESET_ST  = 7'd0,
    FETCH     = 7'd1,
    PC_INC    = 7'd2,
    DECODE    = 7'd3,
    EXEC_R    = 7'd4,
    EXEC_I    = 7'd5,
    ADDR_CALC = 7'd6,
    MEM_RD    = 7'd7,
    MEM_WR    = 7'd8,
    WB_ALU    = 7'd9,
    WB_MEM    = 7'd10,
    BRANCH    = 7'd11,
    JAL       = 7'd12,
    JALR      = 7'd13,
    LUI       = 7'd14,
    TRAP      = 7'd15
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_A  = 1'b1;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_S1 = 2'd3;

  localparam logic [2:0] ALU_LOAD = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_CMP  = 3'd3;

  localparam logic [1:0] M2R_ALU_OUT = 2'd0;
  localparam logic [1:0] M2R_MDR     = 2'd1;
  localparam logic [1:0] M2R_PC      = 2'd2;
  localparam logic [1:0] M2R_IMM     = 2'd3;

  localparam logic [1:0] PCS_ALU     = 2'd0;
  localparam logic [1:0] PCS_ALU_OUT = 2'd1;
  localparam logic [1:0] PCS_JALR    = 2'd2;
  localparam logic [1:0] PCS_EXC     = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       load_a;
    logic       load_b;
    logic       load_alu_out;
    logic       load_mdr;
    logic       reg_write;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_rw;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [2:0] alu_sel;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
    logic       exception;
    logic [1:0] exc_cause;
  } ctrl_t;

  typedef struct packed {
    logic legal;
    logic taken;
  } br_t;

  // Unsigned compares (funct3 110/111) and the reserved 010/011 are not supported.
  function automatic br_t branch_eval(input logic [2:0] funct3,
                                      input logic       zero,
                                      input logic       lt);
    br_t r;
    r.legal = 1'b1;
    r.taken = 1'b0;
    case (funct3)
      3'b000:  r.taken = zero;
      3'b001:  r.taken = !zero;
      3'b100:  r.taken = lt;
      3'b101:  r.taken = !lt;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uc_wait_timer.sv
// Memory wait timer: counts consecutive waiting cycles and flags the cycle in
// which the wait budget is exhausted without a ready strobe.
module uc_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_en,
  output logic timeout
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count_q, count_d;

  // Any non-waiting cycle (other state, or ready seen) restarts the count,
  // so every request starts from zero.
  always_comb begin
    count_d = wait_en ? count_q + 1'b1 : '0;
  end

  // The MAX_WAIT-th waiting cycle is the last one granted.
  assign timeout = wait_en && (count_q == CW'(MAX_WAIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle RV-style control unit: one FSM sequencing fetch, decode, execute,
// memory and write-back, with illegal-opcode and memory-timeout traps.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int unsigned       MEM_WAIT_MAX = 15,
  parameter int unsigned       XLEN         = 64,
  parameter logic [XLEN-1:0]   EXC_VECTOR   = XLEN'('h0FE)
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IR31_0,
  input  logic        ALU_ZERO,
  input  logic        ALU_LT,
  input  logic        IMEM_READY,
  input  logic        DMEM_READY,
  output logic        IR_WRITE,
  output logic        PC_WRITE,
  output logic        LOAD_A,
  output logic        LOAD_B,
  output logic        LOAD_ALU_OUT,
  output logic        LOAD_MDR,
  output logic        REG_WRITE,
  output logic        IMEM_REQ,
  output logic        DMEM_REQ,
  output logic        DMEM_RW,
  output logic        ALU_SRCA,
  output logic [1:0]  ALU_SRCB,
  output logic [2:0]  ALU_SELECTOR,
  output logic [1:0]  MEM_TO_REG,
  output logic [1:0]  PC_SOURCE,
  output logic        EXCEPTION,
  output logic [1:0]  EXC_CAUSE,
  output logic [6:0]  ESTADO_ATUAL
);

  state_e     state_q, state_d;
  logic [1:0] exc_cause_q, exc_cause_d;
  ctrl_t      ctrl;
  logic       wait_en;
  logic       timeout;
  br_t        br;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;

  assign opcode   = IR31_0[6:0];
  assign funct3   = IR31_0[14:12];
  assign funct7_5 = IR31_0[30];
  assign br       = branch_eval(funct3, ALU_ZERO, ALU_LT);

  // The vector is consumed by the datapath; only the opcode/funct fields matter here.
  logic unused_bits;
  assign unused_bits = ^{IR31_0[31], IR31_0[29:15], IR31_0[11:7], EXC_VECTOR};

  assign wait_en = ((state_q == FETCH) && !IMEM_READY) ||
                   (((state_q == MEM_RD) || (state_q == MEM_WR)) && !DMEM_READY);

  uc_wait_timer #(
    .MAX_WAIT (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .wait_en (wait_en),
    .timeout (timeout)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d           = state_q;
    exc_cause_d       = exc_cause_q;
    ctrl              = '0;
    ctrl.alu_sel      = ALU_LOAD;
    ctrl.mem_to_reg   = M2R_ALU_OUT;
    ctrl.pc_source    = PCS_ALU;
    ctrl.exc_cause    = CAUSE_NONE;

    case (state_q)
      RESET_ST: state_d = FETCH;

      FETCH: begin
        ctrl.imem_req = 1'b1;
        if (IMEM_READY) begin
          ctrl.ir_write = 1'b1;
          state_d       = PC_INC;
        end else if (timeout) begin
          exc_cause_d = CAUSE_IMEM_TO;
          state_d     = TRAP;
        end
      end

      PC_INC: begin
        ctrl.alu_srca  = SRCA_PC;
        ctrl.alu_srcb  = SRCB_FOUR;
        ctrl.alu_sel   = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_ALU;
        state_d        = DECODE;
      end

      // Branch/JAL target PC + (imm<<1) is parked in ALU_OUT for every opcode.
      DECODE: begin
        ctrl.load_a       = 1'b1;
        ctrl.load_b       = 1'b1;
        ctrl.alu_srca     = SRCA_PC;
        ctrl.alu_srcb     = SRCB_IMM_S1;
        ctrl.alu_sel      = ALU_ADD;
        ctrl.load_alu_out = 1'b1;
        case (opcode)
          OP_R:               state_d = EXEC_R;
          OP_IMM:             state_d = EXEC_I;
          OP_LOAD, OP_STORE:  state_d = ADDR_CALC;
          OP_BRANCH:          state_d = BRANCH;
          OP_JAL:             state_d = JAL;
          OP_JALR:            state_d = JALR;
          OP_LUI:             state_d = LUI;
          default: begin
            exc_cause_d = CAUSE_ILLEGAL;
            state_d     = TRAP;
          end
        endcase
      end

      EXEC_R: begin
        ctrl.alu_srca     = SRCA_A;
        ctrl.alu_srcb     = SRCB_B;
        ctrl.alu_sel      = funct7_5 ? ALU_SUB : ALU_ADD;
        ctrl.load_alu_out = 1'b1;
        state_d           = WB_ALU;
      end

      EXEC_I: begin
        ctrl.alu_srca     = SRCA_A;
        ctrl.alu_srcb     = SRCB_IMM;
        ctrl.alu_sel      = ALU_ADD;
        ctrl.load_alu_out = 1'b1;
        state_d           = WB_ALU;
      end

      WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_ALU_OUT;
        state_d         = FETCH;
      end

      ADDR_CALC: begin
        ctrl.alu_srca     = SRCA_A;
        ctrl.alu_srcb     = SRCB_IMM;
        ctrl.alu_sel      = ALU_ADD;
        ctrl.load_alu_out = 1'b1;
        state_d           = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        ctrl.dmem_req = 1'b1;
        ctrl.dmem_rw  = 1'b0;
        if (DMEM_READY) begin
          ctrl.load_mdr = 1'b1;
          state_d       = WB_MEM;
        end else if (timeout) begin
          exc_cause_d = CAUSE_DMEM_TO;
          state_d     = TRAP;
        end
      end

      MEM_WR: begin
        ctrl.dmem_req = 1'b1;
        ctrl.dmem_rw  = 1'b1;
        if (DMEM_READY) begin
          state_d = FETCH;
        end else if (timeout) begin
          exc_cause_d = CAUSE_DMEM_TO;
          state_d     = TRAP;
        end
      end

      WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
        state_d         = FETCH;
      end

      BRANCH: begin
        ctrl.alu_srca = SRCA_A;
        ctrl.alu_srcb = SRCB_B;
        ctrl.alu_sel  = ALU_CMP;
        if (!br.legal) begin
          exc_cause_d = CAUSE_ILLEGAL;
          state_d     = TRAP;
        end else begin
          ctrl.pc_write  = br.taken;
          ctrl.pc_source = br.taken ? PCS_ALU_OUT : PCS_ALU;
          state_d        = FETCH;
        end
      end

      JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCS_ALU_OUT;
        state_d         = FETCH;
      end

      JALR: begin
        ctrl.alu_srca   = SRCA_A;
        ctrl.alu_srcb   = SRCB_IMM;
        ctrl.alu_sel    = ALU_ADD;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCS_JALR;
        state_d         = FETCH;
      end

      LUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_IMM;
        state_d         = FETCH;
      end

      TRAP: begin
        ctrl.exception = 1'b1;
        ctrl.exc_cause = exc_cause_q;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_EXC;
        state_d        = FETCH;
      end

      default: state_d = RESET_ST;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= RESET_ST;
      exc_cause_q <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  assign IR_WRITE     = ctrl.ir_write;
  assign PC_WRITE     = ctrl.pc_write;
  assign LOAD_A       = ctrl.load_a;
  assign LOAD_B       = ctrl.load_b;
  assign LOAD_ALU_OUT = ctrl.load_alu_out;
  assign LOAD_MDR     = ctrl.load_mdr;
  assign REG_WRITE    = ctrl.reg_write;
  assign IMEM_REQ     = ctrl.imem_req;
  assign DMEM_REQ     = ctrl.dmem_req;
  assign DMEM_RW      = ctrl.dmem_rw;
  assign ALU_SRCA     = ctrl.alu_srca;
  assign ALU_SRCB     = ctrl.alu_srcb;
  assign ALU_SELECTOR = ctrl.alu_sel;
  assign MEM_TO_REG   = ctrl.mem_to_reg;
  assign PC_SOURCE    = ctrl.pc_source;
  assign EXCEPTION    = ctrl.exception;
  assign EXC_CAUSE    = ctrl.exc_cause;
  assign ESTADO_ATUAL = state_q;

endmodule

// File: doc/uc_multiciclo.md
UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum cycles any memory request waits for its ready before a timeout exception.
REQ-002 Parameter XLEN, default 64: datapath width; the block itself uses only IR31_0, so XLEN only sizes the documented exception vector.
REQ-003 Parameter EXC_VECTOR, default 'h0FE (XLEN wide): exported, not used internally; the datapath selects it when PC_SOURCE=3.
REQ-004 Clocking/reset: one clock; reset is asynchronous and active-low.
REQ-005 CLK  in  1  system clock, rising edge.
REQ-006 RESET_N  in  1  asynchronous active-low reset.
REQ-007 IR31_0  in  32  instruction register contents.
REQ-008 ALU_ZERO, ALU_LT  in  1 each  ALU comparison flags (A==B, A<B signed).
REQ-009 IMEM_READY, DMEM_READY  in  1 each  memory completion strobes.
REQ-010 IR_WRITE, PC_WRITE, LOAD_A, LOAD_B, LOAD_ALU_OUT, LOAD_MDR, REG_WRITE  out  1 each  register load enables.
REQ-011 IMEM_REQ, DMEM_REQ, DMEM_RW  out  1 each  memory request strobes; DMEM_RW 0=read, 1=write.
REQ-012 ALU_SRCA  out  1  0=PC, 1=A; ALU_SRCB  out  2  0=B, 1=const 4, 2=imm, 3=imm<<1.
REQ-013 ALU_SELECTOR  out  3  0=load, 1=add, 2=sub, 3=compare.
REQ-014 MEM_TO_REG  out  2  0=ALU_OUT, 1=MDR, 2=PC, 3=imm (LUI).
REQ-015 PC_SOURCE  out  2  0=ALU result, 1=ALU_OUT, 2=ALU result with bit 0 cleared (JALR), 3=EXC_VECTOR.
REQ-016 EXCEPTION  out  1  high for one cycle on trap; EXC_CAUSE  out  2  1=illegal opcode, 2=IMEM timeout, 3=DMEM timeout.
REQ-017 ESTADO_ATUAL  out  7  current state encoding.

Function
REQ-018 Every output SHALL have an explicit default of 0 in every state; only listed signals are asserted.
REQ-019 States: RESET_ST, FETCH, PC_INC, DECODE, EXEC_R, EXEC_I, ADDR_CALC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, TRAP.
REQ-020 RESET_ST->FETCH unconditionally.
REQ-021 FETCH: IMEM_REQ=1; on IMEM_READY: IR_WRITE=1, ->PC_INC; else stay.
REQ-022 PC_INC: SRCA=0, SRCB=1, SEL=1, PC_WRITE=1, PC_SOURCE=0; ->DECODE.
REQ-023 DECODE: LOAD_A=LOAD_B=1; opcode 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->ADDR_CALC, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, any other->TRAP with cause 1.
REQ-024 EXEC_R: SRCA=1, SRCB=0, SEL=2 when funct7[5]=1 else 1; LOAD_ALU_OUT=1; ->WB_ALU. EXEC_I: same with SRCB=2, SEL=1.
REQ-025 WB_ALU: REG_WRITE=1, MEM_TO_REG=0; ->FETCH.
REQ-026 ADDR_CALC: SRCA=1, SRCB=2, SEL=1, LOAD_ALU_OUT=1; ->MEM_WR if opcode 0100011 else MEM_RD.
REQ-027 MEM_RD: DMEM_REQ=1, DMEM_RW=0; on DMEM_READY LOAD_MDR=1, ->WB_MEM. WB_MEM: REG_WRITE=1, MEM_TO_REG=1; ->FETCH.
REQ-028 MEM_WR: DMEM_REQ=1, DMEM_RW=1; on DMEM_READY ->FETCH.
REQ-029 BRANCH: SRCA=1, SRCB=0, SEL=3; taken when (funct3=000 & ALU_ZERO) | (001 & !ALU_ZERO) | (100 & ALU_LT) | (101 & !ALU_LT); not-taken funct3 values 010/011/110/111 ->TRAP cause 1.
REQ-030 Branch target: ALU_OUT is computed in DECODE (SRCA=0, SRCB=3, SEL=1, LOAD_ALU_OUT=1; harmless for other opcodes); taken branch: PC_WRITE=1, PC_SOURCE=1; ->FETCH in one cycle.
REQ-031 JAL: REG_WRITE=1, MEM_TO_REG=2 (old PC captured by datapath), PC_WRITE=1, PC_SOURCE=1; ->FETCH. JALR: SRCA=1, SRCB=2, SEL=1, REG_WRITE=1, MEM_TO_REG=2, PC_WRITE=1, PC_SOURCE=2; ->FETCH.
REQ-032 LUI: REG_WRITE=1, MEM_TO_REG=3; ->FETCH.
REQ-033 Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR, increments each waiting cycle; when it reaches MEM_WAIT_MAX without ready ->TRAP (cause 2 or 3); ready on that same cycle wins over timeout.
REQ-034 TRAP: EXCEPTION=1, EXC_CAUSE held from entry, PC_WRITE=1, PC_SOURCE=3; ->FETCH.
REQ-035 Writes to x0 are not suppressed here; the register file handles it.

Reset
REQ-036 RESET_N low SHALL asynchronously force RESET_ST, wait counter 0, EXC_CAUSE register 0; all outputs 0 except ESTADO_ATUAL=RESET_ST encoding.
REQ-037 Reset asserted mid-access SHALL abandon the request with no REG_WRITE/PC_WRITE issued.

Structure
REQ-038 State enum, opcode constants, ALU_SELECTOR/MEM_TO_REG/PC_SOURCE encodings and cause codes SHALL live in package uc_pkg.
REQ-039 One sub-module, uc_wait_timer (counter plus timeout compare), SHALL be instantiated; the rest is one FSM.

Verification
REQ-040 ADDI x1,x0,5 with IMEM_READY immediate -> state sequence FETCH,PC_INC,DECODE,EXEC_I,WB_ALU; REG_WRITE=1 exactly once.
REQ-041 SUB (funct7=0100000) -> ALU_SELECTOR=2 in EXEC_R.
REQ-042 LD with DMEM_READY after 3 cycles -> MEM_RD held 4 cycles, LOAD_MDR=1 on the ready cycle, then WB_MEM.
REQ-043 BNE with ALU_ZERO=1 -> no PC_WRITE in BRANCH; BLT with ALU_LT=1 -> PC_WRITE=1, PC_SOURCE=1.
REQ-044 Opcode 1111111 -> TRAP, EXCEPTION=1, EXC_CAUSE=1, PC_SOURCE=3, then FETCH; DMEM_READY never asserted with MEM_WAIT_MAX=15 -> TRAP cause 3 after 15 cycles.
REQ-045 RESET_N pulsed low during MEM_WR -> outputs 0 immediately, RESET_ST, then FETCH after release.
